// File: rtl/kb_pkg.sv
// kb_pkg: shared definitions for the PS/2 keyboard controller.
//   KB_PREFIX_*  : protocol prefix bytes (extended, break, pause)
//   kb_state_t   : decoder states
//   kb_evt_t     : key event {code, ext, brk} carried through the event FIFO
package kb_pkg;

  localparam logic [7:0] KB_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] KB_PREFIX_BRK   = 8'hF0;
  localparam logic [7:0] KB_PREFIX_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } kb_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } kb_evt_t;

  localparam int KB_EVT_W = 10;

endpackage

// File: rtl/kb_evt_fifo.sv
// kb_evt_fifo: show-ahead FIFO for key events.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write request (ignored when full unless a pop happens too)
//   wr_data    : event to write
//   pop        : consumer accepts the head entry (ignored when empty)
//   rd_data    : head entry (forced to zero when empty)
//   full/empty : occupancy flags
//   count      : number of stored entries
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module kb_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Zero the head when empty so outputs are clean out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/kb_scan_ctrl.sv
// kb_scan_ctrl: PS/2 keyboard controller in the system clock domain.
//   i_clk, i_rst_n          : system clock, synchronous active-low reset
//   i_ps2_clk, i_ps2_data   : raw asynchronous PS/2 lines
//   o_evt_valid/i_evt_ready : event handshake, pop when both high
//   o_evt_code/ext/break    : head event (E0-prefixed, F0 release)
//   o_frame_err             : one-cycle pulse on parity/stop/timeout error
//   o_overflow              : sticky, an event was dropped on a full FIFO
//   o_fifo_count            : FIFO occupancy
// Build option: define KB_TYPEMATIC_FILTER_EN to suppress auto-repeat make
// events using a pressed-key map; undefined, every make event is queued.
module kb_scan_ctrl
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ps2_clk,
  input  logic             i_ps2_data,
  output logic             o_evt_valid,
  input  logic             i_evt_ready,
  output logic [7:0]       o_evt_code,
  output logic             o_evt_ext,
  output logic             o_evt_break,
  output logic             o_frame_err,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_fifo_count
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // ---------------- synchronizers ----------------
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;

  // Reset to 1 (idle line level) so no falling edge appears out of reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
    end else begin
      clk_sync_reg[0]  <= i_ps2_clk;
      data_sync_reg[0] <= i_ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync_reg[i]  <= clk_sync_reg[i-1];
        data_sync_reg[i] <= data_sync_reg[i-1];
      end
    end
  end

  assign ps2_clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_reg[SYNC_STAGES-1];

  // ---------------- framer ----------------
  logic            clk_prev_reg;
  logic            fall_edge;
  logic [3:0]      bit_cnt_reg;
  logic [7:0]      data_sh_reg;
  logic            par_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            byte_ok_reg;
  logic            frame_err_reg;

  assign fall_edge = clk_prev_reg && !ps2_clk_s;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_prev_reg  <= 1'b1;
      bit_cnt_reg   <= '0;
      data_sh_reg   <= '0;
      par_reg       <= 1'b0;
      to_cnt_reg    <= '0;
      byte_ok_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      byte_ok_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      clk_prev_reg  <= ps2_clk_s;
      if (fall_edge) begin
        to_cnt_reg <= '0;
        case (bit_cnt_reg)
          // A high start bit is treated as noise: stay waiting, no error.
          4'd0: begin
            if (!ps2_data_s) begin
              bit_cnt_reg <= 4'd1;
            end
          end
          4'd9: begin
            par_reg     <= ps2_data_s;
            bit_cnt_reg <= 4'd10;
          end
          4'd10: begin
            bit_cnt_reg <= 4'd0;
            // Odd parity: data bits plus parity bit must XOR to 1.
            if ((^data_sh_reg ^ par_reg) && ps2_data_s) begin
              byte_ok_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
          default: begin
            data_sh_reg <= {ps2_data_s, data_sh_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end
        endcase
      end else if (bit_cnt_reg != 4'd0) begin
        if (to_cnt_reg == TO_LAST) begin
          bit_cnt_reg   <= 4'd0;
          to_cnt_reg    <= '0;
          frame_err_reg <= 1'b1;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

  // ---------------- decoder FSM ----------------
  kb_state_t state_reg;
  kb_state_t state_next;
  logic      emit;
  kb_evt_t   emit_evt;
  logic      push_next;
  logic      push_reg;
  kb_evt_t   evt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      push_reg  <= 1'b0;
      evt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      push_reg  <= push_next;
      evt_reg   <= emit_evt;
    end
  end

  always_comb begin
    state_next    = state_reg;
    emit          = 1'b0;
    emit_evt.code = data_sh_reg;
    emit_evt.ext  = 1'b0;
    emit_evt.brk  = 1'b0;
    // A bad frame discards any pending prefix.
    if (frame_err_reg) begin
      state_next = S_IDLE;
    end else if (byte_ok_reg) begin
      case (state_reg)
        S_IDLE: begin
          if (data_sh_reg == KB_PREFIX_EXT) begin
            state_next = S_EXT;
          end else if (data_sh_reg == KB_PREFIX_BRK) begin
            state_next = S_BRK;
          end else if (data_sh_reg != KB_PREFIX_PAUSE) begin
            emit = 1'b1;
          end
        end
        S_EXT: begin
          if (data_sh_reg == KB_PREFIX_BRK) begin
            state_next = S_EXT_BRK;
          end else if (data_sh_reg != KB_PREFIX_EXT) begin
            emit         = 1'b1;
            emit_evt.ext = 1'b1;
            state_next   = S_IDLE;
          end
        end
        S_BRK: begin
          emit         = 1'b1;
          emit_evt.brk = 1'b1;
          state_next   = S_IDLE;
        end
        S_EXT_BRK: begin
          emit         = 1'b1;
          emit_evt.ext = 1'b1;
          emit_evt.brk = 1'b1;
          state_next   = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

`ifdef KB_TYPEMATIC_FILTER_EN
  // Pressed-key map indexed by {ext, code[6:0]}; a make for a key already
  // down is an auto-repeat and is not queued.
  logic [255:0] pressed_reg;
  logic [7:0]   key_idx;

  assign key_idx   = {emit_evt.ext, emit_evt.code[6:0]};
  assign push_next = emit && (emit_evt.brk || !pressed_reg[key_idx]);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pressed_reg <= '0;
    end else if (emit) begin
      pressed_reg[key_idx] <= !emit_evt.brk;
    end
  end
`else
  assign push_next = emit;
`endif

  // ---------------- event FIFO ----------------
  kb_evt_t    head_evt;
  logic       fifo_full;
  logic       fifo_empty;
  logic       evt_pop;
  logic       overflow_reg;

  assign evt_pop = !fifo_empty && i_evt_ready;

  kb_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KB_EVT_W)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (push_reg),
    .wr_data (evt_reg),
    .pop     (evt_pop),
    .rd_data (head_evt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      overflow_reg <= 1'b0;
    end else if (push_reg && fifo_full && !evt_pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign o_evt_valid = !fifo_empty;
  assign o_evt_code  = head_evt.code;
  assign o_evt_ext   = head_evt.ext;
  assign o_evt_break = head_evt.brk;
  assign o_frame_err = frame_err_reg;
  assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// tb_kb_scan_ctrl: self-checking bench for kb_scan_ctrl (default build).
module tb_kb_scan_ctrl;

  localparam int DEPTH = 8;
  localparam int TO    = 5000;
  localparam int SYNC  = 2;
  localparam int HALF  = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       frame_err;
  logic       overflow;
  logic [3:0] fifo_count;

  logic auto_mode;
  logic auto_ready;
  logic man_ready;

  assign evt_ready = auto_mode ? auto_ready : man_ready;

  always #5 clk = ~clk;

  kb_scan_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_evt_valid  (evt_valid),
    .i_evt_ready  (evt_ready),
    .o_evt_code   (evt_code),
    .o_evt_ext    (evt_ext),
    .o_evt_break  (evt_break),
    .o_frame_err  (frame_err),
    .o_overflow   (overflow),
    .o_fifo_count (fifo_count)
  );

  int checks = 0;
  int passes = 0;
  int err_cnt = 0;

  // Expected events for the random phase, as {code, ext, brk}.
  logic [9:0] exp_q[$];
  bit m_ext = 1'b0;
  bit m_brk = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // One clock; all bench activity happens on the falling edge.
  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    if (frame_err) err_cnt++;
    if (auto_mode) begin
      auto_ready = ($urandom_range(0, 1) == 1);
      if (evt_valid && auto_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rnd_extra_event: got %h, want no event", {evt_code, evt_ext, evt_break});
        end else begin
          e = exp_q.pop_front();
          chk("rnd_event", int'({evt_code, evt_ext, evt_break}), int'(e));
        end
      end
    end
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic send_bit(logic b);
    ps2_data = b;
    steps(HALF);
    ps2_clk = 1'b0;
    steps(HALF);
    ps2_clk = 1'b1;
  endtask

  // Full frame; optional corrupted parity/stop; optional latency probe on the stop bit.
  task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop, bit lat);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    if (!lat) begin
      send_bit(~bad_stop);
    end else begin
      ps2_data = 1'b1;
      steps(HALF);
      ps2_clk = 1'b0;
      steps(4);
      chk("latency_before", int'(evt_valid), 0);
      steps(1);
      chk("latency_at", int'(evt_valid), 1);
      steps(HALF - 5);
      ps2_clk = 1'b1;
    end
    steps(8);
  endtask

  task automatic good(logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    step();
  endtask

  task automatic chk_head(string name, logic [7:0] code, logic ext, logic brk);
    chk(name, int'({evt_valid, evt_code, evt_ext, evt_break}), int'({1'b1, code, ext, brk}));
  endtask

  // Reference decoder: prefix flags, emit on the first non-prefix byte.
  task automatic model_byte(logic [7:0] b, bit ok);
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m_brk) begin
      exp_q.push_back({b, m_ext, 1'b1});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hE1 && !m_ext) begin
      m_ext = 1'b0;
    end else begin
      exp_q.push_back({b, m_ext, 1'b0});
      m_ext = 1'b0;
    end
  endtask

  typedef struct packed {
    logic [1:0]  n;
    logic [23:0] bytes;  // first byte in [7:0]
    logic [7:0]  code;
    logic        ext;
    logic        brk;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int e0;
    int w;
    int bad_n;
    logic [7:0] b;
    bit bad;

    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    man_ready = 1'b0; auto_ready = 1'b0; auto_mode = 1'b0;
    steps(4);
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_err", int'(frame_err), 0);
    chk("reset_head", int'({evt_code, evt_ext, evt_break}), 0);
    rst_n = 1'b1;
    steps(4);

    // Single make with latency probe.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    chk("make_count", int'(fifo_count), 1);
    chk_head("make_1c", 8'h1C, 1'b0, 1'b0);
    pop_one();
    chk("make_popped", int'(fifo_count), 0);

    // Table of prefix sequences, each yielding exactly one event.
    vecs[0] = '{n: 2'd1, bytes: 24'h00001C, code: 8'h1C, ext: 1'b0, brk: 1'b0};
    vecs[1] = '{n: 2'd2, bytes: 24'h001CF0, code: 8'h1C, ext: 1'b0, brk: 1'b1};
    vecs[2] = '{n: 2'd3, bytes: 24'h75F0E0, code: 8'h75, ext: 1'b1, brk: 1'b1};
    vecs[3] = '{n: 2'd1, bytes: 24'h000029, code: 8'h29, ext: 1'b0, brk: 1'b0};
    vecs[4] = '{n: 2'd3, bytes: 24'h6BE0E0, code: 8'h6B, ext: 1'b1, brk: 1'b0};
    vecs[5] = '{n: 2'd2, bytes: 24'h0014E1, code: 8'h14, ext: 1'b0, brk: 1'b0};
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < int'(vecs[v].n); k++) good(vecs[v].bytes[8*k +: 8]);
      chk($sformatf("vec%0d_count", v), int'(fifo_count), 1);
      chk_head($sformatf("vec%0d_event", v), vecs[v].code, vecs[v].ext, vecs[v].brk);
      pop_one();
    end

    // Parity error, then recovery.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    chk("parity_err_pulse", err_cnt - e0, 1);
    chk("parity_no_event", int'(fifo_count), 0);
    good(8'h32);
    chk_head("parity_recover", 8'h32, 1'b0, 1'b0);
    chk("parity_no_extra_err", err_cnt - e0, 1);
    pop_one();

    // Stop-bit error clears a pending break prefix.
    e0 = err_cnt;
    good(8'hF0);
    send_frame(8'h44, 1'b0, 1'b1, 1'b0);
    chk("stop_err_pulse", err_cnt - e0, 1);
    good(8'h1C);
    chk_head("stop_prefix_dropped", 8'h1C, 1'b0, 1'b0);
    pop_one();

    // A high start bit is ignored silently.
    e0 = err_cnt;
    send_bit(1'b1);
    good(8'h1C);
    chk("start_hi_count", int'(fifo_count), 1);
    chk_head("start_hi_event", 8'h1C, 1'b0, 1'b0);
    chk("start_hi_no_err", err_cnt - e0, 0);
    pop_one();

    // Timeout after 5 bits.
    e0 = err_cnt;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    steps(TO - 100);
    chk("timeout_not_early", err_cnt - e0, 0);
    w = 0;
    while (err_cnt == e0 && w < 400) begin
      step();
      w++;
    end
    steps(4);
    chk("timeout_err_pulse", err_cnt - e0, 1);
    good(8'h1C);
    chk_head("timeout_recover", 8'h1C, 1'b0, 1'b0);
    chk("timeout_count", int'(fifo_count), 1);
    pop_one();

    // Overflow: 9 makes into an 8-deep FIFO.
    for (int k = 0; k < 9; k++) good(8'h15 + 8'(k));
    chk("ovf_count", int'(fifo_count), DEPTH);
    chk("ovf_flag", int'(overflow), 1);
    for (int k = 0; k < DEPTH; k++) begin
      chk_head($sformatf("ovf_drain%0d", k), 8'h15 + 8'(k), 1'b0, 1'b0);
      pop_one();
    end
    chk("ovf_empty", int'(evt_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Reset mid-frame with events queued.
    good(8'h22);
    good(8'h23);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst_n = 1'b0;
    steps(2);
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_head", int'({evt_code, evt_ext, evt_break}), 0);
    rst_n = 1'b1;
    steps(3);
    e0 = err_cnt;
    good(8'h1C);
    chk("post_rst_count", int'(fifo_count), 1);
    chk_head("post_rst_event", 8'h1C, 1'b0, 1'b0);
    chk("post_rst_no_err", err_cnt - e0, 0);
    pop_one();

    // Random byte stream against the reference model with random ready.
    auto_mode = 1'b1;
    e0 = err_cnt;
    bad_n = 0;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 11) == 0);
      if (bad) bad_n++;
      model_byte(b, !bad);
      send_frame(b, bad, 1'b0, 1'b0);
    end
    steps(200);
    auto_mode = 1'b0;
    steps(2);
    chk("rnd_all_consumed", exp_q.size(), 0);
    chk("rnd_fifo_empty", int'(fifo_count), 0);
    chk("rnd_err_count", err_cnt - e0, bad_n);
    chk("rnd_no_overflow", int'(overflow), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
